tanh_act_unit: RTL and testbench



---
 rtl/tanh_act_unit.sv | 150 +++++++++++++++
 tb/tb_tanh_act_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tanh_act_unit.sv
// tanh_act_unit: two-stage pipelined tanh activation for S7.8 fixed point.
// Stage 1 classifies |x| into LIN/LUT/SAT regions and registers the LUT address.
// Stage 2 selects the magnitude, restores the sign and holds the result for the
// valid/ready output port.
// Build option: define TANH_ACT_ROUND_EN to round the LUT address to nearest
// (RND=128); when it is undefined the address is truncated (RND=0).
module tanh_act_unit #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 9,
   parameter int LUT_SIZE   = 276
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      data_in,
   output logic [ADDR_WIDTH-1:0] lut_addr,
   input  logic [WIDTH-1:0]      lut_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      data_out
);

`ifdef TANH_ACT_ROUND_EN
   localparam int unsigned RND = 128;
`else
   localparam int unsigned RND = 0;
`endif

   // 0.25 and 3.00 in S7.8, saturated tanh value 1.0
   localparam logic [WIDTH-1:0] LUT_LO  = WIDTH'('h0040);
   localparam logic [WIDTH-1:0] LUT_HI  = WIDTH'('h0300);
   localparam logic [WIDTH-1:0] SAT_VAL = WIDTH'('h0100);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {
      REGION_LIN,
      REGION_LUT,
      REGION_SAT
   } region_t;

   // stage-1 state
   logic                  s1_valid;
   logic                  s1_sign;
   logic [WIDTH-1:0]      s1_abs;
   logic [WIDTH-1:0]      s1_raw;
   region_t               s1_region;

   // handshake
   logic                  s2_load;
   logic                  s1_adv;

   // stage-1 combinational decode
   logic                  sign_in;
   logic [WIDTH-1:0]      abs_in;
   region_t               region_in;
   logic [31:0]           offset;
   logic [31:0]           scaled;
   logic [ADDR_WIDTH-1:0] addr_in;

   // stage-2 combinational result
   logic [WIDTH-1:0]      mag;
   logic [WIDTH-1:0]      result;

   // The raw sample is carried in stage 1 for debug observation only.
   logic                  unused_raw;
   assign unused_raw = ^s1_raw;

   assign s2_load  = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_load;
   assign in_ready = s1_adv;

   // Sign/magnitude split, region classification and LUT address for the input
   always_comb begin
      sign_in   = data_in[WIDTH-1];
      abs_in    = data_in;
      region_in = REGION_LIN;
      offset    = '0;
      scaled    = '0;
      addr_in   = '0;
      if (data_in == MOST_NEG) begin
         abs_in = MOST_POS;
      end else if (sign_in) begin
         abs_in = -data_in;
      end
      if (abs_in < LUT_LO) begin
         region_in = REGION_LIN;
      end else if (abs_in <= LUT_HI) begin
         region_in = REGION_LUT;
      end else begin
         region_in = REGION_SAT;
      end
      if (region_in == REGION_LUT) begin
         offset = 32'(abs_in) - 32'(LUT_LO);
         scaled = (offset * 32'd100 + RND) >> 8;
         if (scaled > 32'(LUT_SIZE - 1)) begin
            addr_in = ADDR_WIDTH'(LUT_SIZE - 1);
         end else begin
            addr_in = ADDR_WIDTH'(scaled);
         end
      end
   end

   // Stage-1 register: captures the decoded sample whenever stage 1 advances
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_sign   <= 1'b0;
         s1_abs    <= '0;
         s1_raw    <= '0;
         s1_region <= REGION_LIN;
         lut_addr  <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign   <= sign_in;
            s1_abs    <= abs_in;
            s1_raw    <= data_in;
            s1_region <= region_in;
            lut_addr  <= addr_in;
         end
      end
   end

   // Magnitude select by region, then two's-complement negate for negative inputs
   always_comb begin
      mag = '0;
      case (s1_region)
         REGION_LIN: mag = s1_abs;
         REGION_LUT: mag = lut_data;
         default:    mag = SAT_VAL;
      endcase
      result = s1_sign ? -mag : mag;
   end

   // Stage-2 output register: loads when empty or the consumer takes the result
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         data_out  <= '0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            data_out <= result;
         end
      end
   end

endmodule

// File: tb/tb_tanh_act_unit.sv
// Self-checking bench for tanh_act_unit: directed spec vectors, streaming,
// backpressure and mid-stream reset, with a queue scoreboard and a tanh LUT model.
module tb_tanh_act_unit;

`ifdef TANH_ACT_ROUND_EN
   localparam int RND = 128;
   localparam bit ROUND = 1'b1;
`else
   localparam int RND = 0;
   localparam bit ROUND = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] data_in;
   logic [8:0]  lut_addr;
   logic [15:0] lut_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] data_out;

   logic [15:0] lut_rom [0:511];
   logic [15:0] sb [$];
   int          n_checks = 0;
   int          n_pass   = 0;

   assign lut_data = lut_rom[lut_addr];

   always #5 clk = ~clk;

   tanh_act_unit #(
      .WIDTH(16),
      .ADDR_WIDTH(9),
      .LUT_SIZE(276)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .data_in(data_in),
      .lut_addr(lut_addr),
      .lut_data(lut_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .data_out(data_out)
   );

   function automatic logic [15:0] model(input logic [15:0] x);
      logic [15:0] a;
      logic [15:0] m;
      int idx;
      a = x[15] ? (16'h0000 - x) : x;
      if (x == 16'h8000) a = 16'h7FFF;
      if (a < 16'h0040) begin
         m = a;
      end else if (a <= 16'h0300) begin
         idx = ((int'(a) - 64) * 100 + RND) / 256;
         if (idx > 275) idx = 275;
         m = lut_rom[idx];
      end else begin
         m = 16'h0100;
      end
      return x[15] ? (16'h0000 - m) : m;
   endfunction

   function automatic logic [15:0] rand_sample();
      logic [15:0] v;
      v = 16'($urandom_range(0, 16'h0380));
      if ($urandom_range(0, 1) == 1) v = 16'h0000 - v;
      return v;
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
      else n_pass++;
      n_checks++;
      if (data_out !== 16'h0000) $display("FAIL reset_data_out got %h want 0000", data_out);
      else n_pass++;
      n_checks++;
      if (lut_addr !== 9'd0) $display("FAIL reset_lut_addr got %0d want 0", lut_addr);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
      else n_pass++;
   endtask

   task automatic test_vectors();
      logic [15:0] din  [10];
      int          addr [10];
      logic [15:0] dout [10];
      din[0] = 16'h0100; addr[0] = 75;  dout[0] = 16'h00C3;
      din[1] = 16'hFF00; addr[1] = 75;  dout[1] = 16'hFF3D;
      din[2] = 16'h0020; addr[2] = 0;   dout[2] = 16'h0020;
      din[3] = 16'h0040; addr[3] = 0;   dout[3] = 16'h003F;
      din[4] = 16'h0300; addr[4] = 275; dout[4] = 16'h00FF;
      din[5] = 16'h0301; addr[5] = 0;   dout[5] = 16'h0100;
      din[6] = 16'h8000; addr[6] = 0;   dout[6] = 16'hFF00;
      din[7] = 16'h0000; addr[7] = 0;   dout[7] = 16'h0000;
      din[8] = 16'h0042; addr[8] = ROUND ? 1 : 0;
      dout[8] = ROUND ? 16'h0041 : 16'h003F;
      din[9] = 16'hFFC0; addr[9] = 0;   dout[9] = 16'hFFC1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1; data_in = din[i]; out_ready = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         n_checks++;
         if (int'(lut_addr) !== addr[i])
            $display("FAIL vec%0d_lut_addr in=%h got %0d want %0d", i, din[i], lut_addr, addr[i]);
         else n_pass++;
         @(negedge clk);
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || data_out !== dout[i])
            $display("FAIL vec%0d_data_out in=%h got valid=%b %h want valid=1 %h",
                     i, din[i], out_valid, data_out, dout[i]);
         else n_pass++;
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int n = 16;
      logic exp_valid;
      sb.delete();
      for (int c = 0; c < n + 3; c++) begin
         @(negedge clk);
         out_ready = 1'b1;
         in_valid  = (c < n);
         data_in   = rand_sample();
         #1;
         exp_valid = (c >= 2) && (c - 2 < n);
         n_checks++;
         if (in_ready !== 1'b1) $display("FAIL b2b_in_ready c=%0d got %b want 1", c, in_ready);
         else n_pass++;
         n_checks++;
         if (out_valid !== exp_valid)
            $display("FAIL b2b_out_valid c=%0d got %b want %b", c, out_valid, exp_valid);
         else n_pass++;
         if (out_valid && out_ready && sb.size() > 0) begin
            logic [15:0] e;
            e = sb.pop_front();
            n_checks++;
            if (data_out !== e) $display("FAIL b2b_data c=%0d got %h want %h", c, data_out, e);
            else n_pass++;
         end
         if (in_valid && in_ready) sb.push_back(model(data_in));
      end
      in_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [15:0] vec [8];
      bit          pat [4];
      int          sent = 0;
      int          got  = 0;
      int          cyc  = 0;
      logic        stalled = 1'b0;
      logic [15:0] held = '0;
      logic        exp_rdy;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      vec[0] = 16'h0100; vec[1] = 16'hFF00; vec[2] = 16'h0020; vec[3] = 16'h0301;
      for (int i = 4; i < 8; i++) vec[i] = rand_sample();
      sb.delete();
      while (got < 8 && cyc < 200) begin
         @(negedge clk);
         out_ready = pat[cyc % 4];
         in_valid  = (sent < 8);
         data_in   = (sent < 8) ? vec[sent] : 16'h0000;
         #1;
         if (stalled) begin
            n_checks++;
            if (out_valid !== 1'b1 || data_out !== held)
               $display("FAIL bp_hold c=%0d got valid=%b %h want valid=1 %h",
                        cyc, out_valid, data_out, held);
            else n_pass++;
         end
         exp_rdy = !(sb.size() == 2 && !out_ready);
         n_checks++;
         if (in_ready !== exp_rdy)
            $display("FAIL bp_in_ready c=%0d got %b want %b", cyc, in_ready, exp_rdy);
         else n_pass++;
         if (out_valid && out_ready) begin
            logic [15:0] e;
            e = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
            n_checks++;
            if (data_out !== e) $display("FAIL bp_data n=%0d got %h want %h", got, data_out, e);
            else n_pass++;
            got++;
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(data_in));
            sent++;
         end
         stalled = out_valid && !out_ready;
         held    = data_out;
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (got != 8) $display("FAIL bp_timeout got %0d results want 8", got);
      else n_pass++;
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; data_in = 16'h0100;
      @(negedge clk);
      data_in = 16'h0200;
      @(negedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1)
         $display("FAIL mid_full got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
      else n_pass++;
      rst = 1'b1; in_valid = 1'b1; data_in = 16'h0300; out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || data_out !== 16'h0000 || in_ready !== 1'b1 || lut_addr !== 9'd0)
         $display("FAIL mid_reset got valid=%b data=%h in_ready=%b addr=%0d want 0 0000 1 0",
                  out_valid, data_out, in_ready, lut_addr);
      else n_pass++;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if (out_valid !== 1'b0) $display("FAIL mid_discard c=%0d got %b want 0", c, out_valid);
         else n_pass++;
      end
   endtask

   initial begin
      real r;
      for (int i = 0; i < 512; i++) begin
         if (i < 276) begin
            r = $tanh(0.25 + 0.01 * i) * 256.0 + 0.5;
            lut_rom[i] = 16'($rtoi(r));
         end else begin
            lut_rom[i] = 16'h0100;
         end
      end
      rst = 1'b1; in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
      test_reset();
      test_vectors();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
